// File: rtl/basic_adder_pkg.sv
// Local control encodings for the target adder: immediate format and base
// operand select, plus the opcode-to-control decode.
package basic_adder_pkg;
  import isa_pkg::*;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_B,
    FMT_J,
    FMT_U
  } imm_fmt_e;

  typedef enum logic [1:0] {
    BASE_PC,
    BASE_RS1,
    BASE_NPC
  } base_sel_e;

  typedef struct packed {
    imm_fmt_e  fmt;
    base_sel_e base;
    logic      clr_lsb;
  } tgt_ctrl_t;

  // Unknown opcodes fall through to NPC + 0 so nothing undefined leaks out.
  function automatic tgt_ctrl_t decode_tgt(input logic [6:0] opc);
    tgt_ctrl_t c;
    c = '{fmt: FMT_NONE, base: BASE_NPC, clr_lsb: 1'b0};
    case (opc)
      OPC_BRANCH: c = '{fmt: FMT_B, base: BASE_PC,  clr_lsb: 1'b0};
      OPC_JAL:    c = '{fmt: FMT_J, base: BASE_PC,  clr_lsb: 1'b0};
      OPC_JALR:   c = '{fmt: FMT_I, base: BASE_RS1, clr_lsb: 1'b1};
      OPC_AUIPC:  c = '{fmt: FMT_U, base: BASE_PC,  clr_lsb: 1'b0};
      default:    c = '{fmt: FMT_NONE, base: BASE_NPC, clr_lsb: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/isa_pkg.sv
// RV32 opcode constants and packed instruction-format views shared by the
// front end and the functional units.
package isa_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } R_TYPE;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } I_TYPE;

  typedef struct packed {
    logic       imm12;
    logic [5:0] imm10_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm4_1;
    logic       imm11;
    logic [6:0] opcode;
  } B_TYPE;

  typedef struct packed {
    logic       imm20;
    logic [9:0] imm10_1;
    logic       imm11;
    logic [7:0] imm19_12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } J_TYPE;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } U_TYPE;

  typedef union packed {
    logic [31:0] inst;
    R_TYPE       r;
    I_TYPE       i;
    B_TYPE       b;
    J_TYPE       j;
    U_TYPE       u;
  } INST;

endpackage

// File: rtl/sys_defs.sv
// Machine-wide widths and the issue-stage packet layout seen by the
// functional units.
package sys_defs;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] ADDR;
  typedef logic [XLEN-1:0] DATA;

  typedef struct packed {
    isa_pkg::INST inst;
    ADDR          PC;
    ADDR          NPC;
    logic         valid;
  } DECODED_PACKET;

  typedef struct packed {
    DECODED_PACKET decoded_vals;
    logic          valid;
  } RS_PACKET;

  typedef struct packed {
    RS_PACKET decoded_vals;
    DATA      rs1_value;
    DATA      rs2_value;
  } ISSUE_PACKET;

endpackage

// File: rtl/imm_extract.sv
// Sign-extended immediate for the control-flow formats; FMT_NONE yields 0 so
// the base passes through the adder untouched.
module imm_extract
  import isa_pkg::*;
  import basic_adder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  INST             i_inst,
  input  imm_fmt_e        i_fmt,
  output logic [XLEN-1:0] o_imm
);

  logic signed [31:0] w_imm32;
  logic               w_unused_opc;

  assign w_unused_opc = ^i_inst.r.opcode;

  always_comb begin
    w_imm32 = '0;
    case (i_fmt)
      FMT_I: w_imm32 = {{20{i_inst.i.imm[11]}}, i_inst.i.imm};
      FMT_B: w_imm32 = {{19{i_inst.b.imm12}}, i_inst.b.imm12, i_inst.b.imm11,
                        i_inst.b.imm10_5, i_inst.b.imm4_1, 1'b0};
      FMT_J: w_imm32 = {{11{i_inst.j.imm20}}, i_inst.j.imm20, i_inst.j.imm19_12,
                        i_inst.j.imm11, i_inst.j.imm10_1, 1'b0};
      FMT_U: w_imm32 = {i_inst.u.imm, 12'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/basic_adder.sv
// Control-flow target adder: combinational target/misalign for same-cycle use
// by the branch unit, plus a one-cycle registered copy.
module basic_adder
  import sys_defs::ADDR;
  import sys_defs::ISSUE_PACKET;
  import isa_pkg::*;
  import basic_adder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  ISSUE_PACKET is_pack,
  output ADDR         result,
  output logic        misaligned,
  output ADDR         result_q,
  output logic        misaligned_q
);

  if (XLEN != $bits(ADDR)) begin : g_xlen_chk
    $error("basic_adder: XLEN must equal the ADDR width");
  end

  INST             w_inst;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_npc;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;
  tgt_ctrl_t       w_ctrl;
  logic            w_unused;

  assign w_inst = is_pack.decoded_vals.decoded_vals.inst;
  assign w_pc   = is_pack.decoded_vals.decoded_vals.PC;
  assign w_npc  = is_pack.decoded_vals.decoded_vals.NPC;
  assign w_rs1  = is_pack.rs1_value;

  assign w_unused = ^{is_pack.decoded_vals.valid,
                      is_pack.decoded_vals.decoded_vals.valid,
                      is_pack.rs2_value};

  assign w_ctrl = decode_tgt(w_inst.r.opcode);

  imm_extract #(.XLEN(XLEN)) u_imm (
    .i_inst (w_inst),
    .i_fmt  (w_ctrl.fmt),
    .o_imm  (w_imm)
  );

  always_comb begin
    w_base = w_npc;
    case (w_ctrl.base)
      BASE_PC:  w_base = w_pc;
      BASE_RS1: w_base = w_rs1;
      default:  w_base = w_npc;
    endcase
  end

  // Wraps modulo 2^XLEN; JALR drops bit 0 after the add.
  assign w_sum      = w_base + w_imm;
  assign result     = {w_sum[XLEN-1:1], w_sum[0] & ~w_ctrl.clr_lsb};
  assign misaligned = |result[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      result_q     <= result;
      misaligned_q <= misaligned;
    end
  end

endmodule

// File: tb/tb_basic_adder.sv
// Directed vector bench for basic_adder: combinational target, registered
// copy, and asynchronous reset behaviour.
module tb_basic_adder;
  import sys_defs::*;

  logic        clock;
  logic        reset;
  ISSUE_PACKET is_pack;
  ADDR         result;
  logic        misaligned;
  ADDR         result_q;
  logic        misaligned_q;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] rs1;
    logic [31:0] exp_res;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  basic_adder #(.XLEN(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .is_pack      (is_pack),
    .result       (result),
    .misaligned   (misaligned),
    .result_q     (result_q),
    .misaligned_q (misaligned_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] npc, input logic [31:0] rs1);
    ISSUE_PACKET p;
    p = '0;
    p.decoded_vals.decoded_vals.inst  = inst;
    p.decoded_vals.decoded_vals.PC    = pc;
    p.decoded_vals.decoded_vals.NPC   = npc;
    p.decoded_vals.decoded_vals.valid = 1'b1;
    p.decoded_vals.valid              = 1'b1;
    p.rs1_value                       = rs1;
    p.rs2_value                       = 32'hDEAD_BEEF;
    is_pack = p;
  endtask

  // Registered copy holds a known value, then reset lands mid-cycle and must
  // clear it before any clock edge.
  task automatic reset_mid_cycle(input string name, input logic [31:0] inst,
                                 input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] exp_res, input logic exp_mis);
    drive(inst, pc, pc + 32'd4, rs1);
    @(posedge clock); #1;
    chk({name, "_q_before"},   result_q, exp_res);
    chk({name, "_mq_before"},  {31'b0, misaligned_q}, {31'b0, exp_mis});
    #2 reset = 1'b1;
    #1;
    chk({name, "_q_async"},    result_q, 32'h0);
    chk({name, "_mq_async"},   {31'b0, misaligned_q}, 32'h0);
    chk({name, "_comb_rst"},   result, exp_res);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk({name, "_q_after"},    result_q, exp_res);
  endtask

  initial begin
    vecs.push_back('{"beq_back",   32'hFE000CE3, 32'h100,      32'h104, 32'h0,        32'h000000F8, 1'b0});
    vecs.push_back('{"bne_back",   32'hFE001CE3, 32'h100,      32'h104, 32'h0,        32'h000000F8, 1'b0});
    vecs.push_back('{"blt_back",   32'hFE004CE3, 32'h100,      32'h104, 32'h0,        32'h000000F8, 1'b0});
    vecs.push_back('{"br_wrap",    32'h00000463, 32'hFFFFFFFC, 32'h0,   32'h0,        32'h00000004, 1'b0});
    vecs.push_back('{"jal_fwd",    32'h010000EF, 32'h200,      32'h204, 32'h0,        32'h00000210, 1'b0});
    vecs.push_back('{"jal_back",   32'hFFDFF0EF, 32'h200,      32'h204, 32'h0,        32'h000001FC, 1'b0});
    vecs.push_back('{"jal_mis",    32'h002000EF, 32'h100,      32'h104, 32'h0,        32'h00000102, 1'b1});
    vecs.push_back('{"jalr_odd",   32'h00328067, 32'h500,      32'h504, 32'h1000,     32'h00001002, 1'b1});
    vecs.push_back('{"jalr_neg",   32'hFFF00067, 32'h500,      32'h504, 32'h2000,     32'h00001FFE, 1'b1});
    vecs.push_back('{"jalr_wrap",  32'h00400067, 32'h500,      32'h504, 32'hFFFFFFFC, 32'h00000000, 1'b0});
    vecs.push_back('{"auipc",      32'h12345097, 32'h4,        32'h8,   32'h0,        32'h12345004, 1'b0});
    vecs.push_back('{"auipc_neg",  32'hFFFFF017, 32'h10,       32'h14,  32'h0,        32'hFFFFF010, 1'b0});
    vecs.push_back('{"add_npc",    32'h00000033, 32'h100,      32'h108, 32'h55,       32'h00000108, 1'b0});
    vecs.push_back('{"load_npc",   32'h00002003, 32'h100,      32'h7,   32'h55,       32'h00000007, 1'b1});
    vecs.push_back('{"undef_npc",  32'h0000007F, 32'h100,      32'hABC, 32'h55,       32'h00000ABC, 1'b0});

    // Reset held from time zero with a live BEQ on the input.
    reset = 1'b1;
    drive(32'hFE000CE3, 32'h100, 32'h104, 32'h0);
    #2;
    chk("rst_q",        result_q, 32'h0);
    chk("rst_mq",       {31'b0, misaligned_q}, 32'h0);
    chk("rst_comb",     result, 32'h000000F8);
    @(posedge clock); #1;
    chk("rst_hold_q",   result_q, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_rel_q",    result_q, 32'h000000F8);
    chk("rst_rel_mq",   {31'b0, misaligned_q}, 32'h0);

    foreach (vecs[k]) begin
      drive(vecs[k].inst, vecs[k].pc, vecs[k].npc, vecs[k].rs1);
      #2;
      chk({vecs[k].name, "_res"}, result, vecs[k].exp_res);
      chk({vecs[k].name, "_mis"}, {31'b0, misaligned}, {31'b0, vecs[k].exp_mis});
      @(posedge clock); #1;
      chk({vecs[k].name, "_res_q"}, result_q, vecs[k].exp_res);
      chk({vecs[k].name, "_mis_q"}, {31'b0, misaligned_q}, {31'b0, vecs[k].exp_mis});
    end

    reset_mid_cycle("rst_jalr", 32'h00328067, 32'h500, 32'h1000, 32'h00001002, 1'b1);
    reset_mid_cycle("rst_beq",  32'hFE000CE3, 32'h100, 32'h0,    32'h000000F8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/basic_adder.md
BASIC_ADDER -- requirements
Module: basic_adder

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width; must equal the width of ADDR.
REQ-002 SHALL have port clock, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port is_pack, input, ISSUE_PACKET, the issued instruction. Fields used: decoded_vals.decoded_vals.inst, .PC and .NPC, plus rs1_value.
REQ-005 SHALL have port result, output, ADDR, the combinational control-flow target.
REQ-006 SHALL have port misaligned, output, 1, combinational flag: result[1:0] != 0.
REQ-007 SHALL have port result_q, output, ADDR, result registered one cycle.
REQ-008 SHALL have port misaligned_q, output, 1, misaligned registered one cycle.

Function
REQ-009 SHALL decode opcode = inst[6:0] to select base and immediate.
REQ-010 BRANCH (1100011) SHALL give result = PC + B-imm.
  - B-imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
REQ-011 JAL (1101111) SHALL give result = PC + J-imm.
  - J-imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
REQ-012 JALR (1100111) SHALL give result = (rs1_value + sext(inst[31:20])) with bit 0 forced to 0.
REQ-013 AUIPC (0010111) SHALL give result = PC + {inst[31:12], 12'b0}.
REQ-014 Any other opcode SHALL give result = NPC unchanged.
REQ-015 Addition SHALL be XLEN-bit two's-complement, wrapping modulo 2^XLEN; there is no overflow flag.
REQ-016 result and misaligned SHALL be purely combinational (zero latency) with no dependence on clock.
  - Rationale: branch_fu consumes them in the same cycle.
REQ-017 result_q and misaligned_q SHALL load result and misaligned on every rising clock edge while reset is low.
  - Latency 1 cycle; there is no enable.
REQ-018 funct3 SHALL NOT affect the target; all six branch types share the B-imm computation.
REQ-019 No X SHALL propagate for undefined opcodes; REQ-014 applies.

Reset
REQ-020 Asserting reset SHALL immediately, without waiting for a clock edge, set result_q = 0 and misaligned_q = 0.
REQ-021 While reset is held, the registered outputs SHALL stay 0.
REQ-022 result and misaligned SHALL remain combinationally valid during reset.
REQ-023 If reset is deasserted before a rising edge, that edge SHALL capture the current result.

Structure
REQ-024 ADDR, ISSUE_PACKET, RS_PACKET and XLEN SHALL come from the shared sys_defs package.
REQ-025 Opcode constants and the instruction-format unions SHALL come from the shared ISA package.
REQ-026 Immediate extraction SHALL be one sub-module, imm_extract.
  - Inputs: inst and format select.
  - Output: sign-extended immediate.
REQ-027 The adder, base mux and output registers SHALL reside in basic_adder.

Verification
REQ-028 BEQ, inst = 0xFE000CE3, PC = 0x100 -> result = 0x000000F8, misaligned = 0; next cycle result_q = 0xF8.
REQ-029 JAL, inst = 0x010000EF, PC = 0x200 -> result = 0x00000210.
REQ-030 JALR, inst = 0x00328067, rs1_value = 0x1000 -> result = 0x00001002, misaligned = 1.
REQ-031 AUIPC, inst = 0x12345097, PC = 0x4 -> result = 0x12345004; separately, BRANCH with PC = 0xFFFFFFFC and imm +8 -> result = 0x00000004 (wrap).
REQ-032 ADD, inst = 0x00000033, NPC = 0x108 -> result = 0x108.
REQ-033 Assert reset between clock edges while result_q = 0xF8 -> result_q = 0 and misaligned_q = 0 immediately.
